// File: rtl/multilane_circular_buffer.sv
// Multi-lane writable circular operand buffer feeding one PE row.
module multilane_circular_buffer #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned LANES     = 8,
  parameter int unsigned ADDR_W    = $clog2(DEPTH),
  parameter int unsigned LANE_W    = (LANES > 1) ? $clog2(LANES) : 1,
  parameter              INIT_FILE = "var.txt"
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [LANE_W-1:0]       wr_lane,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  output logic                    wr_err,
  input  logic [ADDR_W:0]         cfg_len,
  input  logic                    cfg_circ,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    read_en,
  output logic                    rd_valid,
  output logic [LANES*DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0]       rd_ptr,
  output logic                    wrap,
  output logic                    done,
  output logic                    busy
);

  localparam int unsigned LEN_W  = ADDR_W + 1;
  localparam int unsigned MEM_N  = LANES * DEPTH;
  localparam int unsigned MEM_AW = (MEM_N > 1) ? $clog2(MEM_N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  if (DEPTH < 2 || LANES < 1 || $bits(INIT_FILE) < 8) begin : g_bad_cfg
    $error("multilane_circular_buffer: invalid configuration");
  end

  // Lane-major flat storage: word index lane*DEPTH+addr
  logic [DATA_W-1:0] mem_q [MEM_N];

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0]          len_q, len_d;
  logic                      circ_q, circ_d;
  logic                      rd_valid_q, rd_valid_d;
  logic [LANES*DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                      wrap_q, wrap_d;
  logic                      done_q, done_d;
  logic                      wr_err_q, wr_err_d;
  logic                      busy_q, busy_d;

  logic                      lane_ok_c, addr_ok_c, we_c;
  logic [MEM_AW-1:0]         wr_idx_c;
  logic [LEN_W-1:0]          len_clamp_c;

  // Range checks collapse to constants when the field exactly covers the range
  if (LANES == (1 << LANE_W)) begin : g_lane_full
    assign lane_ok_c = 1'b1;
  end else begin : g_lane_part
    assign lane_ok_c = (wr_lane < LANE_W'(LANES));
  end

  if (DEPTH == (1 << ADDR_W)) begin : g_addr_full
    assign addr_ok_c = 1'b1;
  end else begin : g_addr_part
    assign addr_ok_c = (wr_addr < ADDR_W'(DEPTH));
  end

  assign wr_idx_c    = MEM_AW'(32'(wr_lane) * DEPTH + 32'(wr_addr));
  assign len_clamp_c = (cfg_len == '0 || 32'(cfg_len) > DEPTH) ? LEN_W'(DEPTH) : cfg_len;

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    len_d      = len_q;
    circ_d     = circ_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    wrap_d     = 1'b0;
    done_d     = 1'b0;
    wr_err_d   = 1'b0;
    we_c       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d  = RUN;
          rd_ptr_d = '0;
          len_d    = len_clamp_c;
          circ_d   = cfg_circ;
        end
      end
      RUN: begin
        if (stop) begin
          state_d  = IDLE;
          rd_ptr_d = '0;
        end else if (read_en) begin
          rd_valid_d = 1'b1;
          for (int k = 0; k < int'(LANES); k++) begin
            rd_data_d[k*DATA_W +: DATA_W] = mem_q[MEM_AW'(32'(k) * DEPTH + 32'(rd_ptr_q))];
          end
          if (rd_ptr_q == ADDR_W'(len_q - LEN_W'(1))) begin
            rd_ptr_d = '0;
            wrap_d   = 1'b1;
            if (!circ_q) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end else begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (wr_en) begin
      if (state_q == IDLE && lane_ok_c && addr_ok_c) begin
        we_c = 1'b1;
      end else begin
        wr_err_d = 1'b1;
      end
    end

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      len_q      <= LEN_W'(DEPTH);
      circ_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      wrap_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_err_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      len_q      <= len_d;
      circ_q     <= circ_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      wrap_q     <= wrap_d;
      done_q     <= done_d;
      wr_err_q   <= wr_err_d;
      busy_q     <= busy_d;
    end
  end

  // Storage is retained across reset
  always_ff @(posedge clk) begin
    if (!rst && we_c) begin
      mem_q[wr_idx_c] <= wr_data;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_ptr   = rd_ptr_q;
  assign wrap     = wrap_q;
  assign done     = done_q;
  assign wr_err   = wr_err_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_multilane_circular_buffer.sv
// Bench for multilane_circular_buffer: vector table plus hand sequences, with a
// scoreboard queue of expected read words checked when rd_valid appears.
module tb_multilane_circular_buffer;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned LANES  = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned LANE_W = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    wr_en;
  logic [LANE_W-1:0]       wr_lane;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic                    wr_err;
  logic [ADDR_W:0]         cfg_len;
  logic                    cfg_circ;
  logic                    start;
  logic                    stop;
  logic                    read_en;
  logic                    rd_valid;
  logic [LANES*DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0]       rd_ptr;
  logic                    wrap;
  logic                    done;
  logic                    busy;

  always #5 clk = ~clk;

  multilane_circular_buffer #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .LANES(LANES), .ADDR_W(ADDR_W), .LANE_W(LANE_W),
    .INIT_FILE("var.txt")
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_lane(wr_lane), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_err(wr_err), .cfg_len(cfg_len), .cfg_circ(cfg_circ),
    .start(start), .stop(stop), .read_en(read_en), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_ptr(rd_ptr), .wrap(wrap), .done(done), .busy(busy)
  );

  typedef struct {
    logic       start;
    logic       stop;
    logic       rd;
    logic [3:0] len;
    logic       circ;
    logic       acc;
    logic [2:0] addr;
    logic       wrap;
    logic       done;
    logic [2:0] ptr;
    logic       busy;
  } vec_t;

  typedef struct {
    logic [2:0]              addr;
    logic                    wrap;
    logic                    done;
    logic [LANES*DATA_W-1:0] data;
  } exp_t;

  exp_t        sb[$];
  vec_t        tbl[$];
  logic [15:0] mem_m [LANES][DEPTH];
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic st, input logic sp, input logic rd, input logic [3:0] len,
                              input logic circ, input logic acc, input logic [2:0] addr,
                              input logic wr, input logic dn, input logic [2:0] ptr, input logic bz);
    vec_t v;
    v.start = st; v.stop = sp; v.rd = rd; v.len = len; v.circ = circ; v.acc = acc;
    v.addr = addr; v.wrap = wr; v.done = dn; v.ptr = ptr; v.busy = bz;
    return v;
  endfunction

  // Compare whatever the DUT produced this cycle against the scoreboard
  task automatic check_out(input string tag);
    exp_t e;
    if (rd_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL %s spurious rd_valid: got 1 expected 0", tag);
      end else begin
        e = sb.pop_front();
        for (int k = 0; k < int'(LANES); k++)
          chk($sformatf("%s lane%0d addr%0d", tag, k, e.addr),
              32'(rd_data[k*DATA_W +: DATA_W]), 32'(e.data[k*DATA_W +: DATA_W]));
        chk({tag, " wrap"}, 32'(wrap), 32'(e.wrap));
        chk({tag, " done"}, 32'(done), 32'(e.done));
      end
    end else begin
      if (sb.size() != 0) begin
        n_chk++;
        $display("FAIL %s missing rd_valid: got 0 expected 1", tag);
        void'(sb.pop_front());
      end
      chk({tag, " idle wrap"}, 32'(wrap), 32'd0);
      chk({tag, " idle done"}, 32'(done), 32'd0);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    exp_t e;
    start = v.start; stop = v.stop; read_en = v.rd; cfg_len = v.len; cfg_circ = v.circ;
    if (v.acc) begin
      e.addr = v.addr; e.wrap = v.wrap; e.done = v.done;
      for (int k = 0; k < int'(LANES); k++) e.data[k*DATA_W +: DATA_W] = mem_m[k][v.addr];
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; stop = 1'b0; read_en = 1'b0;
    chk({tag, " ptr"}, 32'(rd_ptr), 32'(v.ptr));
    chk({tag, " busy"}, 32'(busy), 32'(v.busy));
    check_out(tag);
  endtask

  task automatic do_start(input logic [3:0] len, input logic circ, input string tag);
    run_vec(mk(1, 0, 0, len, circ, 0, 0, 0, 0, 0, 1), tag);
  endtask

  task automatic do_stop(input string tag);
    run_vec(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), tag);
  endtask

  task automatic do_read(input int i, input int len, input logic circ, input string tag);
    logic last;
    last = ((i % len) == len - 1);
    run_vec(mk(0, 0, 1, 0, 0, 1, 3'(i % len), last, last & ~circ,
               last ? 3'd0 : 3'((i % len) + 1), ~(last & ~circ)), tag);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_lane = '0; wr_addr = '0; wr_data = '0;
    cfg_len = '0; cfg_circ = 1'b0; start = 1'b0; stop = 1'b0; read_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset rd_valid", 32'(rd_valid), 32'd0);
    chk("reset rd_ptr", 32'(rd_ptr), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset wrap", 32'(wrap), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset wr_err", 32'(wr_err), 32'd0);
    chk("reset rd_data lo", rd_data[31:0], 32'd0);
    chk("reset rd_data hi", rd_data[127:96], 32'd0);
    rst = 1'b0;

    // Load mem[k][a] = k*16+a while idle
    for (int k = 0; k < 8; k++) begin
      for (int a = 0; a < 8; a++) begin
        wr_en = 1'b1; wr_lane = 3'(k); wr_addr = 3'(a); wr_data = 16'(k * 16 + a);
        mem_m[k][a] = 16'(k * 16 + a);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("idle write err l%0d a%0d", k, a), 32'(wr_err), 32'd0);
      end
    end
    wr_en = 1'b0;

    // Circular pass, length 8, ten reads (read_en with start is not accepted)
    tbl.push_back(mk(1, 0, 1, 8, 1, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(0, 0, 1, 0, 0, 1, 3'(i % 8), (i % 8) == 7, 0, 3'((i + 1) % 8), 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    // One-shot length 3, then an unaccepted read in IDLE
    tbl.push_back(mk(1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, 0, 2, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 2, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    // start together with stop stays idle
    tbl.push_back(mk(1, 1, 1, 8, 1, 0, 0, 0, 0, 0, 0));
    // Gapped read_en 1,0,0,1,1
    tbl.push_back(mk(1, 0, 0, 8, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, 0, 2, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 2, 0, 0, 3, 1));
    // start in RUN is ignored: length stays 8, mode stays circular
    tbl.push_back(mk(1, 0, 1, 2, 0, 1, 3, 0, 0, 4, 1));
    for (int a = 4; a < 8; a++)
      tbl.push_back(mk(0, 0, 1, 0, 0, 1, 3'(a), a == 7, 0, 3'((a + 1) % 8), 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Length clamp: 0 and 12 both behave as 8
    do_start(4'd0, 1'b1, "len0 start");
    for (int i = 0; i < 9; i++) do_read(i, 8, 1'b1, "len0 read");
    do_stop("len0 stop");
    do_start(4'd12, 1'b1, "len12 start");
    for (int i = 0; i < 9; i++) do_read(i, 8, 1'b1, "len12 read");
    do_stop("len12 stop");

    // Write during RUN is dropped and flagged one cycle later
    do_start(4'd8, 1'b1, "runwr start");
    wr_en = 1'b1; wr_lane = 3'd2; wr_addr = 3'd4; wr_data = 16'hBEEF;
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "runwr cycle");
    wr_en = 1'b0;
    chk("runwr wr_err pulse", 32'(wr_err), 32'd1);
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "runwr after");
    chk("runwr wr_err clear", 32'(wr_err), 32'd0);
    do_stop("runwr stop");
    do_start(4'd8, 1'b1, "runwr restart");
    for (int i = 0; i < 5; i++) do_read(i, 8, 1'b1, "runwr read");
    chk("runwr lane2 addr4", 32'(rd_data[2*DATA_W +: DATA_W]), 32'h24);

    // Reset mid-RUN at pointer 5
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst rd_valid", 32'(rd_valid), 32'd0);
    chk("midrst rd_ptr", 32'(rd_ptr), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst wrap", 32'(wrap), 32'd0);
    do_start(4'd8, 1'b1, "midrst restart");
    do_read(0, 8, 1'b1, "midrst read");
    chk("midrst lane0 word", 32'(rd_data[DATA_W-1:0]), 32'h00);
    do_stop("midrst stop");

    // Write and start in the same idle cycle: first read sees new data
    wr_en = 1'b1; wr_lane = 3'd5; wr_addr = 3'd0; wr_data = 16'h1234;
    mem_m[5][0] = 16'h1234;
    do_start(4'd8, 1'b1, "wrstart start");
    wr_en = 1'b0;
    chk("wrstart wr_err", 32'(wr_err), 32'd0);
    do_read(0, 8, 1'b1, "wrstart read");
    do_stop("wrstart stop");

    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
